// File: rtl/vram_wr_arbiter_pkg.sv
// vram_pkg: region enum, region address map and decode helpers for the VRAM write arbiter
package vram_pkg;
  typedef enum logic [1:0] {TILE = 2'd0, PATTERN = 2'd1, PALETTE = 2'd2, SPRITE = 2'd3} region_e;
  localparam int NUM_RG = 4;
  localparam logic [31:0] TILE_BASE = 32'h0000;
  localparam logic [31:0] TILE_LIMIT = 32'h07FF;
  localparam logic [31:0] PATTERN_BASE = 32'h0800;
  localparam logic [31:0] PATTERN_LIMIT = 32'h17FF;
  localparam logic [31:0] PALETTE_BASE = 32'h1800;
  localparam logic [31:0] PALETTE_LIMIT = 32'h19FF;
  localparam logic [31:0] SPRITE_BASE = 32'h1A00;
  // Sprite has no upper bound so every address lands in exactly one region
  function automatic region_e region_decode(input logic [31:0] addr);
    return addr <= TILE_LIMIT ? TILE : addr <= PATTERN_LIMIT ? PATTERN : addr <= PALETTE_LIMIT ? PALETTE : SPRITE;
  endfunction
  function automatic logic [31:0] region_base(input region_e r);
    return r == TILE ? TILE_BASE : r == PATTERN ? PATTERN_BASE : r == PALETTE ? PALETTE_BASE : SPRITE_BASE;
  endfunction
endpackage

// File: rtl/vram_wr_arbiter_if.sv
// vram_wr_arbiter_if: writer handshakes and region write ports of the VRAM write arbiter
interface vram_wr_arbiter_if import vram_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic hold;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0][DATA_W/8-1:0] ch_byteena;
  logic [NUM_RG-1:0] rg_wren;
  logic [NUM_RG-1:0][ADDR_W-1:0] rg_addr;
  logic [NUM_RG-1:0][DATA_W-1:0] rg_data;
  logic [NUM_RG-1:0][DATA_W/8-1:0] rg_byteena;
  logic busy;
  modport master (
    output hold, ch_valid, ch_addr, ch_data, ch_byteena,
    input ch_ready, rg_wren, rg_addr, rg_data, rg_byteena, busy
  );
  modport slave (
    input hold, ch_valid, ch_addr, ch_data, ch_byteena,
    output ch_ready, rg_wren, rg_addr, rg_data, rg_byteena, busy
  );
endinterface

// File: rtl/vram_wr_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant among N requests, fixed priority (MODE=0) or round robin from ptr+1 (MODE=1)
module rr_arbiter #(
  parameter int N = 3,
  parameter int MODE = 1,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic w_found;
  always_comb begin
    o_gnt = '0;
    w_win = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (i_en && !w_found && i_req[i] && i == ((MODE != 0 ? int'(r_ptr) + 1 : 0) + k) % N) begin
          o_gnt[i] = 1'b1;
          w_win = PW'(i);
          w_found = 1'b1;
        end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= PW'(N - 1);
    else if (|o_gnt) r_ptr <= w_win;
  assign o_ptr = r_ptr;
endmodule

// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: buffers one write per channel, decodes it to a VRAM region and arbitrates
// each region independently onto a registered region write port
module vram_wr_arbiter import vram_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64,
  parameter int ARB_MODE = 1
) (
  input logic clk,
  input logic rst_n,
  vram_wr_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] r_buf_valid;
  logic [NUM_CH-1:0][ADDR_W-1:0] r_buf_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] r_buf_data;
  logic [NUM_CH-1:0][BE_W-1:0] r_buf_be;
  logic [NUM_RG-1:0][NUM_CH-1:0] w_req;
  logic [NUM_RG-1:0][NUM_CH-1:0] w_gnt_rg;
  logic [NUM_RG-1:0][PW-1:0] w_unused_ptr;
  logic [NUM_CH-1:0] w_gnt;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_RG-1:0][ADDR_W-1:0] w_sel_addr;
  logic [NUM_RG-1:0][DATA_W-1:0] w_sel_data;
  logic [NUM_RG-1:0][BE_W-1:0] w_sel_be;
  logic [NUM_RG-1:0] r_wren;
  logic [NUM_RG-1:0][ADDR_W-1:0] r_addr;
  logic [NUM_RG-1:0][DATA_W-1:0] r_data;
  logic [NUM_RG-1:0][BE_W-1:0] r_be;
  always_comb begin
    w_req = '0;
    for (int r = 0; r < NUM_RG; r++)
      for (int i = 0; i < NUM_CH; i++)
        w_req[r][i] = r_buf_valid[i] && region_decode(32'(r_buf_addr[i])) == region_e'(r);
  end
  for (genvar r = 0; r < NUM_RG; r++) begin : g_rg
    rr_arbiter #(.N(NUM_CH), .MODE(ARB_MODE)) u_arb (
      .clk(clk),
      .rst_n(rst_n),
      .i_req(w_req[r]),
      .i_en(!bus.hold),
      .o_gnt(w_gnt_rg[r]),
      .o_ptr(w_unused_ptr[r])
    );
  end
  // Each channel decodes to a single region, so OR-ing region grants keeps one grant per channel
  always_comb begin
    w_gnt = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_be = '0;
    for (int r = 0; r < NUM_RG; r++)
      for (int i = 0; i < NUM_CH; i++)
        if (w_gnt_rg[r][i]) begin
          w_gnt[i] = 1'b1;
          w_sel_addr[r] = r_buf_addr[i] - ADDR_W'(region_base(region_e'(r)));
          w_sel_data[r] = r_buf_data[i];
          w_sel_be[r] = r_buf_be[i];
        end
  end
  assign bus.ch_ready = ~r_buf_valid | w_gnt;
  assign w_accept = bus.ch_valid & bus.ch_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_buf_valid <= '0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_buf_be <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_accept[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_addr[i] <= bus.ch_addr[i];
          r_buf_data[i] <= bus.ch_data[i];
          r_buf_be[i] <= bus.ch_byteena[i];
        end else if (w_gnt[i]) r_buf_valid[i] <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wren <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_be <= '0;
    end else begin
      for (int r = 0; r < NUM_RG; r++) begin
        r_wren[r] <= |w_gnt_rg[r];
        if (|w_gnt_rg[r]) begin
          r_addr[r] <= w_sel_addr[r];
          r_data[r] <= w_sel_data[r];
          r_be[r] <= w_sel_be[r];
        end
      end
    end
  assign bus.rg_wren = r_wren;
  assign bus.rg_addr = r_addr;
  assign bus.rg_data = r_data;
  assign bus.rg_byteena = r_be;
  assign bus.busy = |r_buf_valid || |r_wren;
endmodule

// File: tb/tb_vram_wr_arbiter.sv
// tb_vram_wr_arbiter: directed bench driving a round-robin and a fixed-priority arbiter with identical stimulus
module tb_vram_wr_arbiter;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic [NUM_CH-1:0] valid = '0;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr = '0;
  logic [NUM_CH-1:0][DATA_W-1:0] data = '0;
  logic [NUM_CH-1:0][7:0] be = '0;
  logic [1:0][3:0] o_wren;
  logic [1:0][3:0][ADDR_W-1:0] o_addr;
  logic [1:0][3:0][DATA_W-1:0] o_data;
  logic [1:0][3:0][7:0] o_be;
  logic [1:0][NUM_CH-1:0] o_ready;
  logic [1:0] o_busy;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  vram_wr_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_rr ();
  vram_wr_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_fp ();
  vram_wr_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_rr));
  vram_wr_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(if_fp));
  assign if_rr.hold = hold;
  assign if_rr.ch_valid = valid;
  assign if_rr.ch_addr = addr;
  assign if_rr.ch_data = data;
  assign if_rr.ch_byteena = be;
  assign if_fp.hold = hold;
  assign if_fp.ch_valid = valid;
  assign if_fp.ch_addr = addr;
  assign if_fp.ch_data = data;
  assign if_fp.ch_byteena = be;
  assign o_wren = {if_fp.rg_wren, if_rr.rg_wren};
  assign o_addr = {if_fp.rg_addr, if_rr.rg_addr};
  assign o_data = {if_fp.rg_data, if_rr.rg_data};
  assign o_be = {if_fp.rg_byteena, if_rr.rg_byteena};
  assign o_ready = {if_fp.ch_ready, if_rr.ch_ready};
  assign o_busy = {if_fp.busy, if_rr.busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_wren[d] !== 4'b0000 || o_busy[d] !== 1'b0 || o_addr[d] !== '0 || o_data[d] !== '0 || o_be[d] !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs dut%0d wren=%b busy=%b addr=%h want zeros", d, o_wren[d], o_busy[d], o_addr[d]);
      end
      n_checks++;
      if (o_ready[d] !== 3'b111) begin
        n_errors++;
        $display("FAIL reset_ready dut%0d got %b want 111", d, o_ready[d]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    valid = 3'b001;
    addr[0] = 13'h1805;
    data[0] = 64'hDEADBEEF_01234567;
    be[0] = 8'hFF;
    tick();
    valid = '0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_wren[d] !== 4'b0100 || o_addr[d][2] !== 13'h005) begin
        n_errors++;
        $display("FAIL single_wren dut%0d wren=%b addr=%h want 0100 005", d, o_wren[d], o_addr[d][2]);
      end
      n_checks++;
      if (o_data[d][2] !== 64'hDEADBEEF_01234567 || o_be[d][2] !== 8'hFF) begin
        n_errors++;
        $display("FAIL single_data dut%0d data=%h be=%h", d, o_data[d][2], o_be[d][2]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_wren[d] !== 4'b0000 || o_busy[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL single_idle dut%0d wren=%b busy=%b want 0000 0", d, o_wren[d], o_busy[d]);
      end
    end
  endtask

  task automatic test_parallel();
    valid = 3'b011;
    addr[0] = 13'h0010;
    data[0] = 64'h1111;
    be[0] = 8'h0F;
    addr[1] = 13'h1A00;
    data[1] = 64'h2222;
    be[1] = 8'h00;
    tick();
    valid = '0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_wren[d] !== 4'b1001 || o_addr[d][0] !== 13'h010 || o_addr[d][3] !== 13'h000) begin
        n_errors++;
        $display("FAIL parallel dut%0d wren=%b tile=%h sprite=%h want 1001 010 000", d, o_wren[d], o_addr[d][0], o_addr[d][3]);
      end
      n_checks++;
      if (o_be[d][3] !== 8'h00 || o_data[d][3] !== 64'h2222 || o_be[d][0] !== 8'h0F) begin
        n_errors++;
        $display("FAIL parallel_be dut%0d be3=%h data3=%h be0=%h", d, o_be[d][3], o_data[d][3], o_be[d][0]);
      end
    end
    tick();
  endtask

  task automatic test_stream();
    int exp_rr[4] = '{0, 1, 2, 0};
    valid = 3'b111;
    for (int i = 0; i < NUM_CH; i++) begin
      addr[i] = 13'(32'h0800 + 32'h10 * i);
      data[i] = 64'(i);
      be[i] = 8'hFF;
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_ready[0] !== 3'(1 << exp_rr[k]) || o_ready[1] !== 3'b001) begin
        n_errors++;
        $display("FAIL stream_ready step%0d rr=%b fp=%b want %b 001", k, o_ready[0], o_ready[1], 3'(1 << exp_rr[k]));
      end
      tick();
      n_checks++;
      if (o_wren[0] !== 4'b0010 || o_addr[0][1] !== 13'(16 * exp_rr[k]) || o_wren[1] !== 4'b0010 || o_addr[1][1] !== 13'h0) begin
        n_errors++;
        $display("FAIL stream_grant step%0d rr=%b/%h fp=%b/%h", k, o_wren[0], o_addr[0][1], o_wren[1], o_addr[1][1]);
      end
    end
    valid = 3'b110;
    #1;
    n_checks++;
    if (o_ready[0] !== 3'b010 || o_ready[1] !== 3'b001) begin
      n_errors++;
      $display("FAIL stream_drop rr=%b fp=%b want 010 001", o_ready[0], o_ready[1]);
    end
    tick();
    n_checks++;
    if (o_addr[0][1] !== 13'h010 || o_addr[1][1] !== 13'h000) begin
      n_errors++;
      $display("FAIL stream_drop_grant rr=%h fp=%h want 010 000", o_addr[0][1], o_addr[1][1]);
    end
    valid = '0;
    #1;
    n_checks++;
    if (o_ready[0] !== 3'b100 || o_ready[1] !== 3'b011) begin
      n_errors++;
      $display("FAIL stream_release rr=%b fp=%b want 100 011", o_ready[0], o_ready[1]);
    end
    repeat (6) tick();
    n_checks++;
    if (o_busy !== 2'b00) begin
      n_errors++;
      $display("FAIL stream_drain busy=%b want 00", o_busy);
    end
  endtask

  task automatic test_hold();
    int order[2][3] = '{'{1, 2, 0}, '{0, 1, 2}};
    hold = 1'b1;
    valid = 3'b111;
    for (int i = 0; i < NUM_CH; i++) begin
      addr[i] = 13'(i);
      data[i] = 64'(32'hA0 + i);
    end
    tick();
    valid = '0;
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_ready[d] !== 3'b000 || o_wren[d] !== 4'b0000 || o_busy[d] !== 1'b1) begin
          n_errors++;
          $display("FAIL hold cyc%0d dut%0d ready=%b wren=%b busy=%b", c, d, o_ready[d], o_wren[d], o_busy[d]);
        end
      end
      tick();
    end
    hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_wren[d] !== 4'b0001 || o_addr[d][0] !== 13'(order[d][k]) || o_data[d][0] !== 64'(32'hA0 + order[d][k])) begin
          n_errors++;
          $display("FAIL hold_drain step%0d dut%0d wren=%b addr=%h want ch%0d", k, d, o_wren[d], o_addr[d][0], order[d][k]);
        end
      end
    end
    tick();
  endtask

  task automatic test_decode();
    logic [12:0] t_addr[6] = '{13'h07FF, 13'h0800, 13'h17FF, 13'h19FF, 13'h1A00, 13'h1FFF};
    int t_rg[6] = '{0, 1, 1, 2, 3, 3};
    logic [12:0] t_loc[6] = '{13'h7FF, 13'h000, 13'hFFF, 13'h1FF, 13'h000, 13'h5FF};
    for (int k = 0; k < 6; k++) begin
      valid = 3'b001;
      addr[0] = t_addr[k];
      tick();
      valid = '0;
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_wren[d] !== 4'(1 << t_rg[k]) || o_addr[d][t_rg[k]] !== t_loc[k]) begin
          n_errors++;
          $display("FAIL decode %h dut%0d wren=%b addr=%h want %b %h", t_addr[k], d, o_wren[d], o_addr[d][t_rg[k]], 4'(1 << t_rg[k]), t_loc[k]);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    valid = 3'b111;
    for (int i = 0; i < NUM_CH; i++) addr[i] = 13'(i);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_wren[d] !== 4'b0000 || o_busy[d] !== 1'b0 || o_addr[d] !== '0 || o_ready[d] !== 3'b111) begin
        n_errors++;
        $display("FAIL reset_mid dut%0d wren=%b busy=%b ready=%b", d, o_wren[d], o_busy[d], o_ready[d]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_ready[d] !== 3'b001) begin
        n_errors++;
        $display("FAIL reset_first_ready dut%0d got %b want 001", d, o_ready[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_wren[d] !== 4'b0001 || o_addr[d][0] !== 13'h000) begin
        n_errors++;
        $display("FAIL reset_first_grant dut%0d wren=%b addr=%h want 0001 000", d, o_wren[d], o_addr[d][0]);
      end
    end
    valid = '0;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_parallel();
    test_stream();
    test_hold();
    test_decode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
